band_feeder: RTL and testbench
==============================

Name: band_feeder

Overview:
- Upstream driver of the PE systolic chain.
- Buffers the query (s) and reference (t) sequences, splits the query into passes of NUM_PE bases, and loads each pass into the array.
- Streams the reference with the boundary H/F/F_hat values into PE 0.
- Captures the last PE's column outputs into a column buffer and replays them as PE 0 boundary inputs on the next pass, so queries longer than the array are supported.

Parameters:
BP_WIDTH, 2, bits per base
CALC_WIDTH, 16, signed score width
NUM_PE, 8, PEs in the chain
MAX_Q, 256, max query length
MAX_T, 256, max reference length; column buffer depth
ADDR_WIDTH, 8, log2(MAX_T), also used for query addressing (MAX_Q == MAX_T)
NEG_INF, -16384, boundary F/F_hat value on pass 0

Ports:
clk  in  1  clock
reset_i  in  1  reset
q_len  in  ADDR_WIDTH+1  query length, sampled at start
t_len  in  ADDR_WIDTH+1  reference length, sampled at start
start  in  1  begin job (pulse)
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
seq_wr_en  in  1  sequence buffer write
seq_wr_sel  in  1  0 = query buffer, 1 = reference buffer
seq_wr_addr  in  ADDR_WIDTH  write address
seq_wr_data  in  BP_WIDTH  base
s_vec_o  out  NUM_PE*BP_WIDTH  query bases for this pass; slice k goes to PE k s_in
s_update_o  out  1  pass load strobe into PE 0 s_update_in
t_o  out  BP_WIDTH  reference base into PE 0
valid_o  out  1  into PE 0 valid_in
H_o  out  CALC_WIDTH  boundary H into PE 0
F_o  out  CALC_WIDTH  boundary F
F_hat_o  out  CALC_WIDTH  boundary F_hat
max_o  out  CALC_WIDTH  constant 0 into PE 0 max_in
pad_mask_o  out  NUM_PE  1 = lane holds padding this pass
pass_idx_o  out  ADDR_WIDTH  current pass number
last_valid_i  in  1  valid_out of PE NUM_PE-1
last_H_i  in  CALC_WIDTH  H_out of last PE
last_F_i  in  CALC_WIDTH  F_out of last PE
last_F_hat_i  in  CALC_WIDTH  F_hat_out of last PE

Behaviour:
- Reset: reset_i is asynchronous, active-low; clock is clk. All outputs reset to 0 and the FSM to IDLE. Buffer contents after reset are undefined. Reset mid-job aborts with no done pulse.
- All outputs are registered.
- Sequence buffer writes take effect only when busy=0. Writes while busy are ignored.
- start is accepted only in IDLE. start while busy is ignored.
- Job setup: npass = ceil(q_len/NUM_PE).
- If q_len==0 or t_len==0, the job goes IDLE -> DONE. busy is high for 1 cycle, then done pulses.
- FSM IDLE: on start, latch the lengths and go to LOAD.
- FSM LOAD, 1 cycle:
  - s_vec_o lane k = query[pass*NUM_PE+k]. Lanes past q_len carry base 0 and have their pad_mask_o bit set.
  - s_update_o=1 for this cycle. s_vec_o stays stable for the whole pass.
  - Prefetch ref[0] and colbuf[0] (synchronous RAM, 1-cycle read latency).
  - Go to STREAM.
- FSM STREAM, t_len cycles, j = 0..t_len-1:
  - valid_o=1 and t_o=ref[j].
  - Pass 0: H_o=0, F_o=NEG_INF, F_hat_o=NEG_INF.
  - Pass p>0: H_o, F_o and F_hat_o take colbuf[j].H, colbuf[j].F and colbuf[j].F_hat.
  - After the final j, valid_o=0 and go to WAIT.
- FSM WAIT:
  - Idle until cap_cnt == t_len.
  - If pass+1 < npass: pass++, clear cap_cnt, go to LOAD.
  - Otherwise go to DONE.
- FSM DONE: done=1 for 1 cycle, busy=0 next cycle, return to IDLE.
- busy=1 in every state except IDLE.
- Capture:
  - While busy and last_valid_i=1, write {last_H_i, last_F_i, last_F_hat_i} to colbuf[cap_cnt], then cap_cnt++.
  - cap_cnt saturates at t_len. Extra last_valid_i pulses are ignored.
  - Within a pass, entry j is read before it is overwritten (read-before-write on the same address).
- Cycle timing from the edge E0 that samples start:
  - s_update_o is high between E1 and E2.
  - valid_o is high from E2 through E(t_len+2), i.e. t_len cycles.
- Arithmetic: the column buffer stores signed values unchanged. Each entry is 3*CALC_WIDTH wide.
- Lengths larger than MAX_Q or MAX_T are clamped to the maximum.

Test Plan:
- Single pass, q_len=4, t_len=5, NUM_PE=8:
  - s_update_o high for exactly 1 cycle.
  - valid_o high for 5 cycles with t_o = ref[0..4].
  - H_o=0 and F_o=F_hat_o=-16384 throughout.
  - pad_mask_o=8'hF0; done pulses once.
- Multi-pass, q_len=20, t_len=6, bench models a 10-cycle array latency:
  - 3 passes; pass_idx_o steps 0, 1, 2.
  - pad_mask_o is 8'h00, 8'h00, 8'hF0.
  - Pass 1/2 H_o/F_o/F_hat_o equal the prior pass's captured values in order.
- Feedback: last_H_i = 100+j on pass 0 -> H_o on pass 1 equals 100..105, aligned with t_o = ref[0..5].
- Zero length: q_len=0 -> busy high for 1 cycle, done pulse, valid_o never high.
- start and seq_wr_en asserted during STREAM -> both ignored. Buffer contents and job progress are unchanged.
- Reset: assert reset_i low on stream cycle 3 -> all outputs 0 immediately, no done pulse. After release, a new start runs normally.

Source files
------------

// File: rtl/band_feeder.sv
// band_feeder: upstream driver of the PE systolic chain. Holds the query and
// reference sequences, loads the query into the array NUM_PE bases per pass,
// streams the reference with boundary H/F/F_hat into PE 0, and captures the last
// PE's column so the next pass can replay it as its left boundary.
module band_feeder #(
    parameter int BP_WIDTH   = 2,
    parameter int CALC_WIDTH = 16,
    parameter int NUM_PE     = 8,
    parameter int MAX_Q      = 256,
    parameter int MAX_T      = 256,
    parameter int ADDR_WIDTH = 8,
    parameter int NEG_INF    = -16384
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [ADDR_WIDTH:0]        q_len,
    input  logic [ADDR_WIDTH:0]        t_len,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic                       seq_wr_en,
    input  logic                       seq_wr_sel,
    input  logic [ADDR_WIDTH-1:0]      seq_wr_addr,
    input  logic [BP_WIDTH-1:0]        seq_wr_data,
    output logic [NUM_PE*BP_WIDTH-1:0] s_vec_o,
    output logic                       s_update_o,
    output logic [BP_WIDTH-1:0]        t_o,
    output logic                       valid_o,
    output logic [CALC_WIDTH-1:0]      H_o,
    output logic [CALC_WIDTH-1:0]      F_o,
    output logic [CALC_WIDTH-1:0]      F_hat_o,
    output logic [CALC_WIDTH-1:0]      max_o,
    output logic [NUM_PE-1:0]          pad_mask_o,
    output logic [ADDR_WIDTH-1:0]      pass_idx_o,
    input  logic                       last_valid_i,
    input  logic [CALC_WIDTH-1:0]      last_H_i,
    input  logic [CALC_WIDTH-1:0]      last_F_i,
    input  logic [CALC_WIDTH-1:0]      last_F_hat_i
);

    localparam int LEN_W   = ADDR_WIDTH + 1;
    localparam int ENTRY_W = 3 * CALC_WIDTH;
    localparam int PE_SH   = $clog2(NUM_PE);
    localparam int IDX_W   = ADDR_WIDTH + PE_SH + 1;

    localparam logic [LEN_W-1:0]      MAX_Q_L   = LEN_W'(MAX_Q);
    localparam logic [LEN_W-1:0]      MAX_T_L   = LEN_W'(MAX_T);
    localparam logic [CALC_WIDTH-1:0] NEG_INF_C = CALC_WIDTH'(NEG_INF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Sequence buffers and the column buffer carried between passes.
    logic [BP_WIDTH-1:0] q_mem   [MAX_Q];
    logic [BP_WIDTH-1:0] t_mem   [MAX_T];
    logic [ENTRY_W-1:0]  col_mem [MAX_T];

    logic [BP_WIDTH-1:0]   t_rd_q;
    logic [ENTRY_W-1:0]    col_rd_q;
    logic [ADDR_WIDTH-1:0] rd_addr;

    logic [LEN_W-1:0] q_len_r, t_len_r, npass_r;
    logic [LEN_W-1:0] str_cnt, cap_cnt;
    logic [LEN_W-1:0] q_len_c, t_len_c, npass_c;

    logic idle, accept, wr_ok, last_beat, cap_done, next_pass, advance, cap_we;
    logic busy_d, done_d, s_update_d, valid_d;

    logic [NUM_PE*BP_WIDTH-1:0] lane_vec;
    logic [NUM_PE-1:0]          lane_pad;
    logic [IDX_W-1:0]           lane_idx;

    // Lengths beyond the buffer depth are clamped; a pass covers NUM_PE query bases.
    assign q_len_c = (q_len > MAX_Q_L) ? MAX_Q_L : q_len;
    assign t_len_c = (t_len > MAX_T_L) ? MAX_T_L : t_len;
    assign npass_c = (q_len_c + LEN_W'(NUM_PE - 1)) >> PE_SH;

    assign idle      = (state_q == S_IDLE);
    assign accept    = idle && start;
    assign wr_ok     = idle && seq_wr_en;
    assign last_beat = (str_cnt == t_len_r - LEN_W'(1));
    assign cap_done  = (cap_cnt == t_len_r);
    assign next_pass = ((LEN_W'(pass_idx_o) + LEN_W'(1)) < npass_r);
    assign advance   = (state_q == S_WAIT) && cap_done && next_pass;
    assign cap_we    = !idle && last_valid_i && (cap_cnt < t_len_r);

    assign max_o = '0;

    // State register.
    // NOTE: every clocked block uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state, next-cycle strobes and buffer read address.
    // NOTE: each variable gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        s_update_d = 1'b0;
        valid_d    = 1'b0;
        rd_addr    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (q_len_c == '0 || t_len_c == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                s_update_d = 1'b1;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                valid_d = 1'b1;
                rd_addr = str_cnt[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
                if (last_beat) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cap_done) state_d = next_pass ? S_LOAD : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Query lanes for the current pass; lanes past the query end are padding.
    always_comb begin
        lane_vec = '0;
        lane_pad = '0;
        lane_idx = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            lane_idx = IDX_W'(pass_idx_o) * IDX_W'(NUM_PE) + IDX_W'(k);
            if (lane_idx < IDX_W'(q_len_r))
                lane_vec[k*BP_WIDTH +: BP_WIDTH] = q_mem[lane_idx[ADDR_WIDTH-1:0]];
            else
                lane_pad[k] = 1'b1;
        end
    end

    // Query buffer: host writes only while idle.
    // NOTE: the buffer arrays have no reset; their contents are meaningless
    // until written, and leaving them unreset lets them map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok && !seq_wr_sel) q_mem[seq_wr_addr] <= seq_wr_data;
    end

    // Reference buffer: host writes while idle, one-cycle synchronous read.
    always_ff @(posedge clk) begin
        if (wr_ok && seq_wr_sel) t_mem[seq_wr_addr] <= seq_wr_data;
        t_rd_q <= t_mem[rd_addr];
    end

    // Column buffer: the read returns the old entry when it shares an address with a capture.
    always_ff @(posedge clk) begin
        if (cap_we) col_mem[cap_cnt[ADDR_WIDTH-1:0]] <= {last_H_i, last_F_i, last_F_hat_i};
        col_rd_q <= col_mem[rd_addr];
    end

    // Job lengths, pass number, stream counter and saturating capture counter.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            q_len_r    <= '0;
            t_len_r    <= '0;
            npass_r    <= '0;
            pass_idx_o <= '0;
            str_cnt    <= '0;
            cap_cnt    <= '0;
        end else begin
            if (accept) begin
                q_len_r    <= q_len_c;
                t_len_r    <= t_len_c;
                npass_r    <= npass_c;
                pass_idx_o <= '0;
            end else if (advance) begin
                pass_idx_o <= pass_idx_o + ADDR_WIDTH'(1);
            end

            str_cnt <= (state_q == S_STREAM && !last_beat) ? str_cnt + LEN_W'(1) : '0;

            if (accept || advance) cap_cnt <= '0;
            else if (cap_we)       cap_cnt <= cap_cnt + LEN_W'(1);
        end
    end

    // Registered outputs toward PE 0 and the host.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            s_update_o <= 1'b0;
            valid_o    <= 1'b0;
            s_vec_o    <= '0;
            pad_mask_o <= '0;
            t_o        <= '0;
            H_o        <= '0;
            F_o        <= '0;
            F_hat_o    <= '0;
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            s_update_o <= s_update_d;
            valid_o    <= valid_d;

            if (state_q == S_LOAD) begin
                s_vec_o    <= lane_vec;
                pad_mask_o <= lane_pad;
            end

            if (state_q == S_STREAM) begin
                t_o <= t_rd_q;
                if (pass_idx_o == '0) begin
                    H_o     <= '0;
                    F_o     <= NEG_INF_C;
                    F_hat_o <= NEG_INF_C;
                end else begin
                    {H_o, F_o, F_hat_o} <= col_rd_q;
                end
            end else begin
                t_o     <= '0;
                H_o     <= '0;
                F_o     <= '0;
                F_hat_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_band_feeder.sv
// tb_band_feeder: directed bench for band_feeder with a fixed-latency model of
// the PE chain feeding the capture port.
`timescale 1ns/1ps
module tb_band_feeder;

    localparam int NEG_INF = -16384;
    localparam int LAT     = 10;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [8:0]  q_len = '0;
    logic [8:0]  t_len = '0;
    logic        start = 1'b0;
    logic        busy, done;
    logic        seq_wr_en = 1'b0;
    logic        seq_wr_sel = 1'b0;
    logic [7:0]  seq_wr_addr = '0;
    logic [1:0]  seq_wr_data = '0;
    logic [15:0] s_vec_o;
    logic        s_update_o;
    logic [1:0]  t_o;
    logic        valid_o;
    logic [15:0] H_o, F_o, F_hat_o, max_o;
    logic [7:0]  pad_mask_o;
    logic [7:0]  pass_idx_o;
    logic        last_valid_i = 1'b0;
    logic [15:0] last_H_i = '0;
    logic [15:0] last_F_i = '0;
    logic [15:0] last_F_hat_i = '0;

    int checks = 0;
    int failures = 0;

    logic [1:0] ref_tbl [8];

    // Per-job observations.
    int         n_beats, n_upd, upd_first, n_done, done_cyc, n_busy, inj_cyc;
    logic       end_busy;
    int         b_t [64], b_h [64], b_f [64], b_fh [64], b_pass [64], b_cyc [64];
    logic [7:0] b_pad [64];
    logic [15:0] b_svec [64];

    // PE chain model.
    int         model_pass = 0;
    int         model_j = 0;
    logic [LAT-1:0] vdly = '0;

    band_feeder dut (
        .clk          (clk),
        .reset_i      (reset_i),
        .q_len        (q_len),
        .t_len        (t_len),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .seq_wr_en    (seq_wr_en),
        .seq_wr_sel   (seq_wr_sel),
        .seq_wr_addr  (seq_wr_addr),
        .seq_wr_data  (seq_wr_data),
        .s_vec_o      (s_vec_o),
        .s_update_o   (s_update_o),
        .t_o          (t_o),
        .valid_o      (valid_o),
        .H_o          (H_o),
        .F_o          (F_o),
        .F_hat_o      (F_hat_o),
        .max_o        (max_o),
        .pad_mask_o   (pad_mask_o),
        .pass_idx_o   (pass_idx_o),
        .last_valid_i (last_valid_i),
        .last_H_i     (last_H_i),
        .last_F_i     (last_F_i),
        .last_F_hat_i (last_F_hat_i)
    );

    always #5 clk = ~clk;

    // Array model: each valid beat re-emerges LAT cycles later with a column
    // value that encodes (pass, j): H=100+16p+j, F=-200-16p-j, F_hat=1000+16p+j.
    always @(negedge clk) begin
        if (s_update_o) begin
            model_pass = model_pass + 1;
            model_j    = 0;
        end
        vdly = {vdly[LAT-2:0], valid_o};
        if (vdly[LAT-1]) begin
            last_valid_i = 1'b1;
            last_H_i     = 16'(100 + 16 * model_pass + model_j);
            last_F_i     = 16'(-200 - 16 * model_pass - model_j);
            last_F_hat_i = 16'(1000 + 16 * model_pass + model_j);
            model_j      = model_j + 1;
        end else begin
            last_valid_i = 1'b0;
        end
    end

    function automatic logic [1:0] qb(input int i);
        return 2'((i * i + i / 3 + 1) % 4);
    endfunction

    function automatic logic [15:0] exp_svec(input int p, input int ql);
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 8; k++)
            if (p * 8 + k < ql) v[k*2 +: 2] = qb(p * 8 + k);
        return v;
    endfunction

    function automatic logic [7:0] exp_pad(input int p, input int ql);
        logic [7:0] v;
        v = '0;
        for (int k = 0; k < 8; k++)
            if (p * 8 + k >= ql) v[k] = 1'b1;
        return v;
    endfunction

    task automatic wr(input logic sel, input int addr, input logic [1:0] d);
        @(negedge clk);
        seq_wr_en   = 1'b1;
        seq_wr_sel  = sel;
        seq_wr_addr = 8'(addr);
        seq_wr_data = d;
        @(negedge clk);
        seq_wr_en = 1'b0;
    endtask

    // Starts a job and records every cycle until two cycles after done.
    // Cycle c=0 is the cycle right after the edge that samples start.
    task automatic run_job(input int ql, input int tl);
        int ended;
        ended     = -1;
        n_beats   = 0;
        n_upd     = 0;
        upd_first = -1;
        n_done    = 0;
        done_cyc  = -1;
        n_busy    = 0;
        @(negedge clk);
        model_pass = -1;
        q_len = 9'(ql);
        t_len = 9'(tl);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (busy) n_busy++;
            if (s_update_o) begin
                n_upd++;
                if (upd_first < 0) upd_first = c;
            end
            if (valid_o && n_beats < 64) begin
                b_t[n_beats]    = int'(t_o);
                b_h[n_beats]    = int'($signed(H_o));
                b_f[n_beats]    = int'($signed(F_o));
                b_fh[n_beats]   = int'($signed(F_hat_o));
                b_pass[n_beats] = int'(pass_idx_o);
                b_pad[n_beats]  = pad_mask_o;
                b_svec[n_beats] = s_vec_o;
                b_cyc[n_beats]  = c;
                n_beats++;
            end
            if (done) begin
                n_done++;
                if (ended < 0) begin
                    ended    = c;
                    done_cyc = c;
                end
            end
            if (c == inj_cyc) begin
                start       = 1'b1;
                q_len       = 9'd16;
                t_len       = 9'd7;
                seq_wr_en   = 1'b1;
                seq_wr_sel  = 1'b1;
                seq_wr_addr = 8'd2;
                seq_wr_data = ~ref_tbl[2];
            end else if (c == inj_cyc + 1) begin
                start       = 1'b0;
                seq_wr_sel  = 1'b0;
                seq_wr_addr = 8'd1;
                seq_wr_data = ~qb(1);
            end else if (c == inj_cyc + 2) begin
                seq_wr_en = 1'b0;
            end
            if (ended >= 0 && c == ended + 2) break;
            @(negedge clk);
        end
        end_busy = busy;
        checks++;
        if (ended < 0) begin
            failures++;
            $display("FAIL job_timeout: got no done pulse within 600 cycles, required one (q=%0d t=%0d)", ql, tl);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, s_update_o, valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000", {busy, done, s_update_o, valid_o});
        end
        checks++;
        if ({s_vec_o, t_o, H_o, F_o, F_hat_o, max_o, pad_mask_o, pass_idx_o} !== '0) begin
            failures++;
            $display("FAIL reset_data: got nonzero data outputs, required all 0");
        end
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b valid=%b required 0 0", busy, valid_o);
        end
    endtask

    task automatic test_single;
        run_job(4, 5);
        checks++;
        if (n_upd !== 1 || upd_first !== 1) begin
            failures++;
            $display("FAIL single_s_update: got %0d pulses first at c=%0d, required 1 at c=1", n_upd, upd_first);
        end
        checks++;
        if (n_beats !== 5) begin
            failures++;
            $display("FAIL single_beats: got %0d required 5", n_beats);
        end
        checks++;
        if (b_cyc[0] !== 2 || b_cyc[4] !== 6) begin
            failures++;
            $display("FAIL single_valid_window: got c=%0d..%0d required 2..6", b_cyc[0], b_cyc[4]);
        end
        for (int b = 0; b < 5; b++) begin
            checks++;
            if (b_t[b] !== int'(ref_tbl[b])) begin
                failures++;
                $display("FAIL single_t[%0d]: got %0d required %0d", b, b_t[b], ref_tbl[b]);
            end
            checks++;
            if (b_h[b] !== 0 || b_f[b] !== NEG_INF || b_fh[b] !== NEG_INF) begin
                failures++;
                $display("FAIL single_bound[%0d]: got H=%0d F=%0d Fh=%0d required 0 %0d %0d",
                         b, b_h[b], b_f[b], b_fh[b], NEG_INF, NEG_INF);
            end
        end
        checks++;
        if (b_pad[0] !== 8'hF0 || b_pass[0] !== 0) begin
            failures++;
            $display("FAIL single_pad: got pad=%h pass=%0d required f0 0", b_pad[0], b_pass[0]);
        end
        checks++;
        if (b_svec[0] !== exp_svec(0, 4)) begin
            failures++;
            $display("FAIL single_svec: got %h required %h", b_svec[0], exp_svec(0, 4));
        end
        checks++;
        if (n_done !== 1 || n_busy !== done_cyc + 1 || end_busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got done=%0d busy_cycles=%0d (done at c=%0d) end_busy=%b required 1 pulse, busy through done, then 0",
                     n_done, n_busy, done_cyc, end_busy);
        end
    endtask

    task automatic test_multi_pass;
        int p, j, eh, ef, efh;
        run_job(20, 6);
        checks++;
        if (n_upd !== 3 || n_beats !== 18 || n_done !== 1) begin
            failures++;
            $display("FAIL multi_counts: got upd=%0d beats=%0d done=%0d required 3 18 1", n_upd, n_beats, n_done);
        end
        for (int b = 0; b < 18; b++) begin
            p   = b / 6;
            j   = b % 6;
            eh  = (p == 0) ? 0       : 100 + 16 * (p - 1) + j;
            ef  = (p == 0) ? NEG_INF : -200 - 16 * (p - 1) - j;
            efh = (p == 0) ? NEG_INF : 1000 + 16 * (p - 1) + j;
            checks++;
            if (b_pass[b] !== p || b_t[b] !== int'(ref_tbl[j])) begin
                failures++;
                $display("FAIL multi_stream[%0d]: got pass=%0d t=%0d required %0d %0d", b, b_pass[b], b_t[b], p, ref_tbl[j]);
            end
            checks++;
            if (b_h[b] !== eh || b_f[b] !== ef || b_fh[b] !== efh) begin
                failures++;
                $display("FAIL multi_bound[%0d]: got H=%0d F=%0d Fh=%0d required %0d %0d %0d",
                         b, b_h[b], b_f[b], b_fh[b], eh, ef, efh);
            end
            checks++;
            if (b_pad[b] !== exp_pad(p, 20) || b_svec[b] !== exp_svec(p, 20)) begin
                failures++;
                $display("FAIL multi_lanes[%0d]: got pad=%h svec=%h required %h %h",
                         b, b_pad[b], b_svec[b], exp_pad(p, 20), exp_svec(p, 20));
            end
        end
    endtask

    task automatic test_feedback;
        run_job(9, 6);
        checks++;
        if (n_beats !== 12 || n_upd !== 2) begin
            failures++;
            $display("FAIL fb_counts: got beats=%0d upd=%0d required 12 2", n_beats, n_upd);
        end
        checks++;
        if (b_pad[0] !== 8'h00 || b_pad[6] !== 8'hFE) begin
            failures++;
            $display("FAIL fb_pad: got %h %h required 00 fe", b_pad[0], b_pad[6]);
        end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (b_h[6 + j] !== 100 + j || b_t[6 + j] !== int'(ref_tbl[j])) begin
                failures++;
                $display("FAIL fb_H[%0d]: got H=%0d t=%0d required %0d %0d", j, b_h[6 + j], b_t[6 + j], 100 + j, ref_tbl[j]);
            end
        end
    endtask

    task automatic test_zero_len;
        run_job(0, 5);
        checks++;
        if (n_busy !== 1 || n_done !== 1 || n_beats !== 0 || n_upd !== 0) begin
            failures++;
            $display("FAIL zero_q: got busy=%0d done=%0d beats=%0d upd=%0d required 1 1 0 0", n_busy, n_done, n_beats, n_upd);
        end
        run_job(4, 0);
        checks++;
        if (n_busy !== 1 || n_done !== 1 || n_beats !== 0) begin
            failures++;
            $display("FAIL zero_t: got busy=%0d done=%0d beats=%0d required 1 1 0", n_busy, n_done, n_beats);
        end
    endtask

    task automatic test_ignore_busy;
        inj_cyc = 3;
        run_job(4, 5);
        inj_cyc = -10;
        checks++;
        if (n_beats !== 5 || n_done !== 1 || n_upd !== 1 || end_busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_job: got beats=%0d done=%0d upd=%0d end_busy=%b required 5 1 1 0", n_beats, n_done, n_upd, end_busy);
        end
        for (int b = 0; b < 5; b++) begin
            checks++;
            if (b_t[b] !== int'(ref_tbl[b])) begin
                failures++;
                $display("FAIL ign_t[%0d]: got %0d required %0d", b, b_t[b], ref_tbl[b]);
            end
        end
        run_job(4, 5);
        checks++;
        if (b_t[2] !== int'(ref_tbl[2]) || b_svec[0] !== exp_svec(0, 4)) begin
            failures++;
            $display("FAIL ign_buffers: got t2=%0d svec=%h required %0d %h", b_t[2], b_svec[0], ref_tbl[2], exp_svec(0, 4));
        end
    endtask

    task automatic test_reset_midjob;
        int n_d, n_b;
        n_d = 0;
        n_b = 0;
        @(negedge clk);
        model_pass = -1;
        q_len = 9'd4;
        t_len = 9'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (valid_o !== 1'b1 || F_o !== 16'(NEG_INF)) begin
            failures++;
            $display("FAIL rst_pre: got valid=%b F=%h required 1 %h", valid_o, F_o, 16'(NEG_INF));
        end
        reset_i = 1'b0;
        #1;
        checks++;
        if ({busy, done, s_update_o, valid_o} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_mid_ctrl: got %b required 0000", {busy, done, s_update_o, valid_o});
        end
        checks++;
        if (F_o !== '0 || F_hat_o !== '0 || t_o !== '0 || H_o !== '0 || max_o !== '0) begin
            failures++;
            $display("FAIL rst_mid_stream: got t=%h H=%h F=%h Fh=%h required 0", t_o, H_o, F_o, F_hat_o);
        end
        checks++;
        if (s_vec_o !== '0 || pad_mask_o !== '0 || pass_idx_o !== '0) begin
            failures++;
            $display("FAIL rst_mid_lanes: got svec=%h pad=%h pass=%h required 0", s_vec_o, pad_mask_o, pass_idx_o);
        end
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (done) n_d++;
            if (busy) n_b++;
        end
        checks++;
        if (n_d !== 0 || n_b !== 0) begin
            failures++;
            $display("FAIL rst_abort: got done=%0d busy=%0d cycles required 0 0", n_d, n_b);
        end
        run_job(4, 5);
        checks++;
        if (n_beats !== 5 || n_done !== 1 || b_t[3] !== int'(ref_tbl[3]) || b_f[0] !== NEG_INF) begin
            failures++;
            $display("FAIL rst_rerun: got beats=%0d done=%0d t3=%0d F=%0d required 5 1 %0d %0d",
                     n_beats, n_done, b_t[3], b_f[0], ref_tbl[3], NEG_INF);
        end
    endtask

    initial begin
        ref_tbl = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd2};
        inj_cyc = -10;
        test_reset;
        for (int i = 0; i < 32; i++) wr(1'b0, i, qb(i));
        for (int i = 0; i < 8; i++)  wr(1'b1, i, ref_tbl[i]);
        test_single;
        test_multi_pass;
        test_feedback;
        test_zero_len;
        test_ignore_busy;
        test_reset_midjob;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test by 2 ms, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
